spi_mstr_param: RTL

SPI_MSTR_PARAM -- requirements
Module: spi_mstr_param

---
 rtl/spi_mstr_param_if.sv | 30 +++
 rtl/spi_mstr_param.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/spi_mstr_param_if.sv
// Host/SPI bundle for spi_mstr_param. The master modport is the SPI master
// itself; the slave modport is whatever drives requests and MISO.
interface spi_mstr_param_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_SS = 1,
  parameter int SSW    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
);
  logic              wrt;
  logic [WIDTH-1:0]  cmd;
  logic [SSW-1:0]    ss_sel;
  logic [1:0]        nframes;
  logic              MISO;
  logic              SCLK;
  logic              MOSI;
  logic [NUM_SS-1:0] SS_n;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_vld;
  logic              done;
  logic              busy;

  modport master (
    input  wrt, cmd, ss_sel, nframes, MISO,
    output SCLK, MOSI, SS_n, rd_data, rd_vld, done, busy
  );

  modport slave (
    output wrt, cmd, ss_sel, nframes, MISO,
    input  SCLK, MOSI, SS_n, rd_data, rd_vld, done, busy
  );
endinterface

// File: rtl/spi_mstr_param.sv
// Parameterised SPI master: 1..4 back-to-back frames per request, selectable
// CPOL/CPHA, one-hot active-low slave select with out-of-range select muted.
module spi_mstr_param #(
  parameter int WIDTH     = 16,
  parameter int SCLK_HALF = 16,
  parameter int NUM_SS    = 1,
  parameter bit CPOL      = 1'b1,
  parameter bit CPHA      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_mstr_param_if.master  bus
);

  localparam int SSW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int HW  = $clog2(SCLK_HALF) + 1;
  localparam int EW  = $clog2(2 * WIDTH) + 1;

  localparam logic [HW-1:0] H_LAST = HW'(SCLK_HALF - 1);
  localparam logic [EW-1:0] E_LAST = EW'(2 * WIDTH);

  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP} state_t;

  state_t            st;
  logic [HW-1:0]     hcnt;
  logic [EW-1:0]     ecnt;
  logic [WIDTH-1:0]  tx_sh, rx_sh, rd_data_q;
  logic [1:0]        frm_left;
  logic [NUM_SS-1:0] ss_mask, ss_n_q;
  logic              sclk_q, rd_vld_q, done_q, busy_q;

  logic [EW-1:0]     e_next;
  logic              half_end, leading, do_samp, do_shift;

  // Active-low one-hot select; an index past NUM_SS leaves every line high.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SSW-1:0] sel);
    ss_decode = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (int'(sel) == i) ss_decode[i] = 1'b0;
  endfunction

  // Edge bookkeeping: edge numbers start at 1, odd edges are leading.
  always_comb begin
    e_next   = ecnt + EW'(1);
    half_end = (hcnt == H_LAST);
    leading  = e_next[0];
    do_samp  = CPHA ? ~leading : leading;
    do_shift = CPHA ? (leading && (e_next != EW'(1))) : ~leading;
  end

  // Frame sequencer: FRONT / SHIFT / BACK per frame, GAP between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      hcnt      <= '0;
      ecnt      <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rd_data_q <= '0;
      frm_left  <= '0;
      ss_mask   <= '1;
      ss_n_q    <= '1;
      sclk_q    <= CPOL;
      rd_vld_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rd_vld_q <= 1'b0;
      case (st)
        IDLE: begin
          hcnt <= '0;
          if (bus.wrt) begin
            tx_sh    <= bus.cmd;
            rx_sh    <= '0;
            frm_left <= bus.nframes;
            ss_mask  <= ss_decode(bus.ss_sel);
            ss_n_q   <= ss_decode(bus.ss_sel);
            ecnt     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            st       <= FRONT;
          end
        end
        FRONT: begin
          if (half_end) begin
            hcnt <= '0;
            ecnt <= '0;
            st   <= SHIFT;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        SHIFT: begin
          if (half_end) begin
            hcnt   <= '0;
            ecnt   <= e_next;
            sclk_q <= (e_next == E_LAST) ? CPOL : ~sclk_q;
            if (do_samp)  rx_sh <= {rx_sh[WIDTH-2:0], bus.MISO};
            if (do_shift) tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
            if (e_next == E_LAST) st <= BACK;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        BACK: begin
          if (half_end) begin
            hcnt      <= '0;
            rd_data_q <= rx_sh;
            rd_vld_q  <= 1'b1;
            ss_n_q    <= '1;
            if (frm_left == 2'd0) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              st     <= IDLE;
            end else begin
              // Follow-on frames transmit zeros.
              frm_left <= frm_left - 2'd1;
              tx_sh    <= '0;
              st       <= GAP;
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        GAP: begin
          if (half_end) begin
            hcnt   <= '0;
            ecnt   <= '0;
            ss_n_q <= ss_mask;
            st     <= FRONT;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // MOSI is forced low whenever no slave is selected.
  assign bus.MOSI    = tx_sh[WIDTH-1] & ~(&ss_n_q);
  assign bus.SCLK    = sclk_q;
  assign bus.SS_n    = ss_n_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_vld  = rd_vld_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule
